painterengine_gpu_stream_fifo: RTL and testbench



---
 rtl/painterengine_gpu_stream_fifo_if.sv | 12 +
 rtl/painterengine_gpu_stream_fifo.sv | 117 +++++++++++
 tb/tb_painterengine_gpu_stream_fifo.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/painterengine_gpu_stream_fifo_if.sv
// rtl/painterengine_gpu_stream_fifo_if.sv - word stream with data/valid/next handshake
interface painterengine_gpu_stream_fifo_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data;
   logic                  data_valid;
   logic                  data_next;

   // Producer side drives the word and its valid; consumer answers with next
   modport master (output data, output data_valid, input data_next);
   modport slave  (input data, input data_valid, output data_next);
endinterface

// File: rtl/painterengine_gpu_stream_fifo.sv
// rtl/painterengine_gpu_stream_fifo.sv - DMA reader channel elastic buffer, optional PAINTERENGINE_GPU_FIFO_LEVEL_EN level output
module painterengine_gpu_stream_fifo #(
   parameter int DATA_WIDTH         = 32,
   parameter int DEPTH_LOG2         = 4,
   parameter int ALMOST_FULL_MARGIN = 2
) (
   input  logic                            i_wire_clock,
   input  logic                            i_wire_resetn,
   input  logic                            i_wire_start,
   input  logic [31:0]                     i_wire_length,
   painterengine_gpu_stream_fifo_if.slave  upstream,
   painterengine_gpu_stream_fifo_if.master downstream,
   output logic                            o_wire_almost_full,
   output logic                            o_wire_done,
`ifdef PAINTERENGINE_GPU_FIFO_LEVEL_EN
   output logic [DEPTH_LOG2:0]             o_wire_level,
`endif
   output logic                            o_wire_error
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_L  = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] MARGIN_L = (DEPTH_LOG2+1)'(ALMOST_FULL_MARGIN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]    level_q;
   logic [31:0]            in_count, out_count, length_q;
   logic [15:0]            timeout_q;
   logic                   start_ok, wr_en, rd_en, in_ready, out_valid;

   assign start_ok  = i_wire_start && ((state_q == IDLE) || (state_q == DONE));
   // No full-bypass: a full buffer refuses input even when a read is happening
   assign in_ready  = (state_q == RUN) && (level_q < DEPTH_L) && (in_count < length_q);
   assign out_valid = (state_q == RUN) && (level_q != '0);
   assign wr_en     = upstream.data_valid && in_ready;
   assign rd_en     = out_valid && downstream.data_next;

   assign upstream.data_next    = in_ready;
   assign downstream.data_valid = out_valid;
   assign downstream.data       = mem[rd_ptr];
   assign o_wire_almost_full    = (state_q == RUN) && ((DEPTH_L - level_q) <= MARGIN_L);
   assign o_wire_done           = (state_q == DONE);
   assign o_wire_error          = (state_q == ERROR);
`ifdef PAINTERENGINE_GPU_FIFO_LEVEL_EN
   assign o_wire_level          = (state_q == RUN) ? level_q : '0;
`endif

   // State register
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) state_q <= IDLE;
      else                state_q <= state_d;
   end

   // Next-state logic: completion beats a same-cycle timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (i_wire_start) state_d = (i_wire_length == 32'd0) ? ERROR : RUN;
         end
         RUN: begin
            if (rd_en && ((out_count + 32'd1) == length_q)) state_d = DONE;
            else if (timeout_q == 16'hFFFF)                 state_d = ERROR;
         end
         ERROR:   state_d = ERROR;
         default: state_d = IDLE;
      endcase
   end

   // Storage array; stale contents are harmless because pointers gate visibility
   always_ff @(posedge i_wire_clock) begin
      if (wr_en) mem[wr_ptr] <= upstream.data;
   end

   // Pointers, level, word counters and idle timeout
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level_q   <= '0;
         in_count  <= '0;
         out_count <= '0;
         length_q  <= '0;
         timeout_q <= '0;
      end else if (start_ok && (i_wire_length != 32'd0)) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level_q   <= '0;
         in_count  <= '0;
         out_count <= '0;
         length_q  <= i_wire_length;
         timeout_q <= '0;
      end else if (state_q == RUN) begin
         if (wr_en) begin
            wr_ptr   <= wr_ptr + 1'b1;
            in_count <= in_count + 32'd1;
         end
         if (rd_en) begin
            rd_ptr    <= rd_ptr + 1'b1;
            out_count <= out_count + 32'd1;
         end
         if (wr_en && !rd_en)      level_q <= level_q + 1'b1;
         else if (!wr_en && rd_en) level_q <= level_q - 1'b1;
         timeout_q <= (wr_en || rd_en) ? 16'd0 : timeout_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_painterengine_gpu_stream_fifo.sv
// tb/tb_painterengine_gpu_stream_fifo.sv - directed self-checking bench for the stream fifo
module tb_painterengine_gpu_stream_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] length;
   logic        almost_full, done, error;
`ifdef PAINTERENGINE_GPU_FIFO_LEVEL_EN
   logic [4:0]  level;
`endif
   int          n_checks = 0;
   int          n_fail   = 0;

   painterengine_gpu_stream_fifo_if #(.DATA_WIDTH(32)) up_if ();
   painterengine_gpu_stream_fifo_if #(.DATA_WIDTH(32)) dn_if ();

   painterengine_gpu_stream_fifo #(
      .DATA_WIDTH(32), .DEPTH_LOG2(4), .ALMOST_FULL_MARGIN(2)
   ) dut (
      .i_wire_clock       (clk),
      .i_wire_resetn      (rst_n),
      .i_wire_start       (start),
      .i_wire_length      (length),
      .upstream           (up_if),
      .downstream         (dn_if),
      .o_wire_almost_full (almost_full),
      .o_wire_done        (done),
`ifdef PAINTERENGINE_GPU_FIFO_LEVEL_EN
      .o_wire_level       (level),
`endif
      .o_wire_error       (error)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      up_if.data_valid = 1'b0;
      dn_if.data_next  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; length = '0;
      up_if.data = '0; up_if.data_valid = 1'b0; dn_if.data_next = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({up_if.data_next, dn_if.data_valid, almost_full, done, error} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b required 00000",
                  {up_if.data_next, dn_if.data_valid, almost_full, done, error});
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({up_if.data_next, dn_if.data_valid, done, error} !== 4'b0) begin
         n_fail++;
         $display("FAIL idle_outputs: got %b required 0000",
                  {up_if.data_next, dn_if.data_valid, done, error});
      end
   endtask

   task automatic test_basic();
      int wcnt = 0, rcnt = 0, cyc = 0, last_rd = -1;
      logic wr, rd;
      start = 1'b1; length = 32'd5;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (up_if.data_next !== 1'b1 || dn_if.data_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_run_entry: next=%b valid=%b required next=1 valid=0",
                  up_if.data_next, dn_if.data_valid);
      end
      up_if.data = 32'h10; up_if.data_valid = 1'b1; dn_if.data_next = 1'b1;
      while (rcnt < 5 && cyc < 30) begin
         wr = up_if.data_valid && up_if.data_next;
         rd = dn_if.data_valid && dn_if.data_next;
         if (rd) begin
            n_checks++;
            if (dn_if.data !== 32'h10 + rcnt) begin
               n_fail++;
               $display("FAIL basic_data: got %h required %h", dn_if.data, 32'h10 + rcnt);
            end
            rcnt++; last_rd = cyc;
         end
         if (wr) wcnt++;
         @(negedge clk); cyc++;
         if (wr) begin
            up_if.data = 32'h10 + wcnt;
            if (wcnt == 5) up_if.data_valid = 1'b0;
         end
      end
      n_checks++;
      if (last_rd != 5) begin
         n_fail++;
         $display("FAIL basic_latency: last read at cycle %0d required 5", last_rd);
      end
      n_checks++;
      if (done !== 1'b1 || dn_if.data_valid !== 1'b0 || up_if.data_next !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done: done=%b valid=%b next=%b required 1 0 0",
                  done, dn_if.data_valid, up_if.data_next);
      end
   endtask

   task automatic test_full();
      int wcnt = 0, rcnt = 0, cyc = 0;
      logic wr, rd;
      dn_if.data_next = 1'b0;
      start = 1'b1; length = 32'd20;
      @(negedge clk);
      start = 1'b0;
      up_if.data = 32'h100; up_if.data_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wr = up_if.data_valid && up_if.data_next;
         if (wr) wcnt++;
         @(negedge clk);
         if (wr) up_if.data = 32'h100 + wcnt;
         n_checks++;
         if (almost_full !== (wcnt >= 14)) begin
            n_fail++;
            $display("FAIL full_almost_full: level=%0d got %b required %b",
                     wcnt, almost_full, (wcnt >= 14));
         end
      end
      n_checks++;
      if (wcnt != 16 || up_if.data_next !== 1'b0 || dn_if.data_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL full_stall: writes=%0d next=%b valid=%b required 16 0 1",
                  wcnt, up_if.data_next, dn_if.data_valid);
      end
      dn_if.data_next = 1'b1;
      while (rcnt < 20 && cyc < 80) begin
         wr = up_if.data_valid && up_if.data_next;
         rd = dn_if.data_valid && dn_if.data_next;
         if (rd) begin
            n_checks++;
            if (dn_if.data !== 32'h100 + rcnt) begin
               n_fail++;
               $display("FAIL full_data: got %h required %h", dn_if.data, 32'h100 + rcnt);
            end
            rcnt++;
         end
         if (wr) wcnt++;
         @(negedge clk); cyc++;
         if (wr) begin
            up_if.data = 32'h100 + wcnt;
            if (wcnt == 20) up_if.data_valid = 1'b0;
         end
      end
      n_checks++;
      if (rcnt != 20 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL full_done: reads=%0d done=%b required 20 1", rcnt, done);
      end
   endtask

   task automatic test_wrap();
      int wcnt = 0, rcnt = 0, cyc = 0, gaps = 0, last_rd = -1;
      logic wr, rd;
      start = 1'b1; length = 32'd40;
      @(negedge clk);
      start = 1'b0;
      up_if.data = 32'h1000; up_if.data_valid = 1'b1; dn_if.data_next = 1'b1;
      while (rcnt < 40 && cyc < 100) begin
         if (cyc >= 1 && dn_if.data_valid !== 1'b1) gaps++;
         wr = up_if.data_valid && up_if.data_next;
         rd = dn_if.data_valid && dn_if.data_next;
         if (rd) begin
            n_checks++;
            if (dn_if.data !== 32'h1000 + rcnt) begin
               n_fail++;
               $display("FAIL wrap_data: got %h required %h", dn_if.data, 32'h1000 + rcnt);
            end
            rcnt++; last_rd = cyc;
         end
         if (wr) wcnt++;
         @(negedge clk); cyc++;
         if (wr) begin
            up_if.data = 32'h1000 + wcnt;
            if (wcnt == 40) up_if.data_valid = 1'b0;
         end
      end
      n_checks++;
      if (gaps != 0 || last_rd != 40 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_stream: gaps=%0d last_rd=%0d done=%b required 0 40 1",
                  gaps, last_rd, done);
      end
   endtask

   task automatic test_excess();
      int wcnt = 0, rcnt = 0, cyc = 0;
      logic wr, rd;
      dn_if.data_next = 1'b0;
      start = 1'b1; length = 32'd3;
      @(negedge clk);
      start = 1'b0;
      up_if.data = 32'h200; up_if.data_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr = up_if.data_valid && up_if.data_next;
         if (wr) wcnt++;
         @(negedge clk);
         if (wr) up_if.data = 32'h200 + wcnt;
      end
      n_checks++;
      if (wcnt != 3 || up_if.data_next !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL excess_accept: writes=%0d next=%b error=%b required 3 0 0",
                  wcnt, up_if.data_next, error);
      end
      dn_if.data_next = 1'b1;
      while (rcnt < 3 && cyc < 20) begin
         wr = up_if.data_valid && up_if.data_next;
         rd = dn_if.data_valid && dn_if.data_next;
         if (rd) begin
            n_checks++;
            if (dn_if.data !== 32'h200 + rcnt) begin
               n_fail++;
               $display("FAIL excess_data: got %h required %h", dn_if.data, 32'h200 + rcnt);
            end
            rcnt++;
         end
         if (wr) wcnt++;
         @(negedge clk); cyc++;
      end
      up_if.data_valid = 1'b0;
      n_checks++;
      if (done !== 1'b1 || error !== 1'b0 || wcnt != 3) begin
         n_fail++;
         $display("FAIL excess_done: done=%b error=%b writes=%0d required 1 0 3",
                  done, error, wcnt);
      end
   endtask

   task automatic test_len0_error();
      start = 1'b1; length = 32'd0;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (error !== 1'b1 || up_if.data_next !== 1'b0 || dn_if.data_valid !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL len0_error: error=%b next=%b valid=%b done=%b required 1 0 0 0",
                  error, up_if.data_next, dn_if.data_valid, done);
      end
      start = 1'b1; length = 32'd4;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (error !== 1'b1 || up_if.data_next !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL len0_sticky: error=%b next=%b done=%b required 1 0 0",
                  error, up_if.data_next, done);
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      do_reset();
      start = 1'b1; length = 32'd1;
      @(negedge clk);
      start = 1'b0;
      while (error !== 1'b1 && n < 70000) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n != 65536) begin
         n_fail++;
         $display("FAIL timeout_cycles: error after %0d cycles required 65536", n);
      end
      start = 1'b1; length = 32'd2;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (error !== 1'b1 || up_if.data_next !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_sticky: error=%b next=%b required 1 0", error, up_if.data_next);
      end
   endtask

   task automatic test_reset_mid();
      int wcnt = 0, rcnt = 0, cyc = 0;
      logic wr, rd;
      do_reset();
      start = 1'b1; length = 32'd20;
      @(negedge clk);
      start = 1'b0;
      up_if.data = 32'h300; up_if.data_valid = 1'b1;
      while (wcnt < 7 && cyc < 20) begin
         wr = up_if.data_valid && up_if.data_next;
         if (wr) wcnt++;
         @(negedge clk); cyc++;
         if (wr) up_if.data = 32'h300 + wcnt;
         if (wcnt == 7) up_if.data_valid = 1'b0;
      end
      n_checks++;
      if (dn_if.data_valid !== 1'b1 || wcnt != 7) begin
         n_fail++;
         $display("FAIL mid_fill: valid=%b writes=%0d required 1 7", dn_if.data_valid, wcnt);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({up_if.data_next, dn_if.data_valid, almost_full, done, error} !== 5'b0) begin
         n_fail++;
         $display("FAIL mid_async_reset: got %b required 00000",
                  {up_if.data_next, dn_if.data_valid, almost_full, done, error});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b1; length = 32'd2;
      @(negedge clk);
      start = 1'b0;
      up_if.data = 32'h55; up_if.data_valid = 1'b1; dn_if.data_next = 1'b1;
      wcnt = 0; cyc = 0;
      while (rcnt < 2 && cyc < 20) begin
         wr = up_if.data_valid && up_if.data_next;
         rd = dn_if.data_valid && dn_if.data_next;
         if (rd) begin
            n_checks++;
            if (dn_if.data !== 32'h55 + rcnt) begin
               n_fail++;
               $display("FAIL mid_restart_data: got %h required %h", dn_if.data, 32'h55 + rcnt);
            end
            rcnt++;
         end
         if (wr) wcnt++;
         @(negedge clk); cyc++;
         if (wr) begin
            up_if.data = 32'h55 + wcnt;
            if (wcnt == 2) up_if.data_valid = 1'b0;
         end
      end
      n_checks++;
      if (rcnt != 2 || done !== 1'b1 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_restart_done: reads=%0d done=%b error=%b required 2 1 0",
                  rcnt, done, error);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_wrap();
      test_excess();
      test_len0_error();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
